// File: rtl/rv_imm_pkg.sv
// rtl/rv_imm_pkg.sv - immediate-class encodings, FSM state type and the reference extender
package rv_imm_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Decode side of the encoder: rebuilds the byte-unit immediate from instr[31:7].
    function automatic logic [31:0] imm_extend(input logic [31:7] instr, input logic [1:0] src);
        logic [31:0] ext;
        case (src)
            IMM_I:   ext = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/imm_encode_if.sv
// rtl/imm_encode_if.sv - request and instruction-memory write bundle for imm_encode
interface imm_encode_if #(
    parameter int AW = 6
);
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    ImmSrc;
    logic [31:0]   imm;
    logic [31:0]   base;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic          err;
    logic [AW:0]   wr_count;

    modport master (
        output clear, in_valid, ImmSrc, imm, base, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, err, wr_count
    );

    modport slave (
        input  clear, in_valid, ImmSrc, imm, base, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, err, wr_count
    );
endinterface

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - range-checks an immediate and scatters it into the class-specific fields
module imm_pack
    import rv_imm_pkg::*;
(
    input  logic [1:0]  imm_src_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] base_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // A sign-extended field means every bit above the field's msb equals it.
    logic fits_12;
    logic fits_13;
    logic fits_21;

    assign fits_12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits_13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits_21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        word_o  = base_i;
        legal_o = 1'b0;
        case (imm_src_i)
            IMM_I: begin
                legal_o       = fits_12;
                word_o[31:20] = imm_i[11:0];
            end
            IMM_S: begin
                legal_o       = fits_12;
                word_o[31:25] = imm_i[11:5];
                word_o[11:7]  = imm_i[4:0];
            end
            IMM_B: begin
                legal_o       = fits_13 & ~imm_i[0];
                word_o[31]    = imm_i[12];
                word_o[30:25] = imm_i[10:5];
                word_o[11:8]  = imm_i[4:1];
                word_o[7]     = imm_i[11];
            end
            default: begin
                legal_o       = fits_21 & ~imm_i[0];
                word_o[31]    = imm_i[20];
                word_o[30:21] = imm_i[10:1];
                word_o[20]    = imm_i[11];
                word_o[19:12] = imm_i[19:12];
            end
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - encodes requests and writes them to instruction memory at an
// auto-incrementing address, flagging illegal immediates with a sticky error.
module imm_encode
    import rv_imm_pkg::*;
#(
    parameter int AW = 6
) (
    input logic         clk,
    input logic         reset_n,
    imm_encode_if.slave bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          in_ready;
    logic          mem_we;
    logic [31:0]   packed_word;
    logic          packed_legal;

    imm_pack u_pack (
        .imm_src_i (bus.ImmSrc),
        .imm_i     (bus.imm),
        .base_i    (bus.base),
        .word_o    (packed_word),
        .legal_o   (packed_legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~bus.clear;
                // clear wins over a simultaneous request
                if (bus.clear) begin
                    addr_d = '0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                end else if (bus.in_valid) begin
                    if (packed_legal) begin
                        wdata_d = packed_word;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                mem_we = 1'b1;
                if (bus.mem_ready) begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;
    assign bus.wr_count  = cnt_q;

endmodule
